// File: rtl/sincos2saw_pkg.sv
// Shared types and constants for the sin/cos-to-phase CORDIC.
// The arctangent table is in phase LSBs (2^16 per turn).
package sincos2saw_pkg;

  localparam int unsigned PHASE_W = 16;
  localparam int unsigned CORE_W  = 18;
  localparam int unsigned K_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Working vector of the rotation: x/y in 18-bit two's complement, z is phase.
  typedef struct packed {
    logic signed [CORE_W-1:0]  x;
    logic signed [CORE_W-1:0]  y;
    logic        [PHASE_W-1:0] z;
  } vec_t;

  // round(atan(2^-k) * 65536 / (2*pi))
  function automatic logic [PHASE_W-1:0] atan_lut(input logic [K_W-1:0] k);
    logic [PHASE_W-1:0] a;
    case (k)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      4'd14:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sincos2saw_if.sv
// Sample-in / phase-out handshake bundle for sincos2saw.
interface sincos2saw_if;

  logic [sincos2saw_pkg::PHASE_W-1:0] i_cos;
  logic [sincos2saw_pkg::PHASE_W-1:0] i_sin;
  logic                               i_valid;
  logic                               o_ready;
  logic [sincos2saw_pkg::PHASE_W-1:0] o_saw;
  logic                               o_valid;
  logic                               i_ready;

  modport slave (
    input  i_cos, i_sin, i_valid, i_ready,
    output o_ready, o_saw, o_valid
  );

  modport master (
    output i_cos, i_sin, i_valid, i_ready,
    input  o_ready, o_saw, o_valid
  );

endinterface

// File: rtl/sincos2saw_cordic_vec_step.sv
// One vectoring-mode CORDIC micro-rotation: steers y toward zero and
// accumulates the rotated angle into z. Purely combinational.
module sincos2saw_cordic_vec_step
  import sincos2saw_pkg::*;
(
  input  vec_t           v_in,
  input  logic [K_W-1:0] k,
  output vec_t           v_out_c
);

  logic signed [CORE_W-1:0] x;
  logic signed [CORE_W-1:0] y;
  logic signed [CORE_W-1:0] xs;
  logic signed [CORE_W-1:0] ys;
  logic [PHASE_W-1:0]       a;

  always_comb begin
    x       = v_in.x;
    y       = v_in.y;
    xs      = x >>> k;
    ys      = y >>> k;
    a       = atan_lut(k);
    v_out_c = v_in;
    if (!y[CORE_W-1]) begin
      v_out_c.x = x + ys;
      v_out_c.y = y - xs;
      v_out_c.z = v_in.z + a;
    end else begin
      v_out_c.x = x - ys;
      v_out_c.y = y + xs;
      v_out_c.z = v_in.z - a;
    end
  end

endmodule

// File: rtl/sincos2saw.sv
// Recovers a 16-bit sawtooth phase from an offset-binary sin/cos pair using an
// iterative vectoring CORDIC, one micro-rotation per clock.
module sincos2saw
  import sincos2saw_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sincos2saw_if.slave bus
);

  localparam logic [K_W-1:0] K_LAST = K_W'(ITERATIONS - 1);

  state_e             state_q, state_d;
  vec_t               vec_q, vec_d, step_c;
  logic [K_W-1:0]     k_q, k_d;
  logic               zero_q, zero_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [PHASE_W-1:0] saw_q, saw_d;

  logic                     accept_c;
  logic signed [CORE_W-1:0] cos_c;
  logic signed [CORE_W-1:0] sin_c;

  // Offset binary to sign-extended two's complement.
  always_comb begin
    cos_c    = {{(CORE_W-PHASE_W+1){~bus.i_cos[PHASE_W-1]}}, bus.i_cos[PHASE_W-2:0]};
    sin_c    = {{(CORE_W-PHASE_W+1){~bus.i_sin[PHASE_W-1]}}, bus.i_sin[PHASE_W-2:0]};
    accept_c = bus.i_valid && ready_q;
  end

  sincos2saw_cordic_vec_step u_step (
    .v_in    (vec_q),
    .k       (k_q),
    .v_out_c (step_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      saw_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      saw_q   <= saw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ROT;
      ROT:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d   = vec_q;
    k_d     = k_q;
    zero_d  = zero_q;
    ready_d = ready_q;
    valid_d = valid_q;
    saw_d   = saw_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          // Fold left half-plane onto the right so the rotation range suffices.
          if (cos_c[CORE_W-1]) begin
            vec_d.x = -cos_c;
            vec_d.y = -sin_c;
            vec_d.z = 16'h8000;
          end else begin
            vec_d.x = cos_c;
            vec_d.y = sin_c;
            vec_d.z = 16'h0000;
          end
          zero_d  = (cos_c == '0) && (sin_c == '0);
          k_d     = '0;
          ready_d = 1'b0;
        end
      end
      ROT: begin
        // A zero vector has no angle: hold z at its loaded zero.
        if (!zero_q) vec_d = step_c;
        k_d = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          valid_d = 1'b1;
          saw_d   = vec_d.z;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_saw   = saw_q;

endmodule

// File: tb/tb_sincos2saw.sv
// Scoreboard bench for sincos2saw: directed quadrant vectors, loopback sweep,
// backpressure and mid-operation reset.
module tb_sincos2saw;

  localparam int unsigned ITER = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sincos2saw_if bus();

  sincos2saw #(.ITERATIONS(ITER)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] saw;
    int          tol;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic bit near(input logic [15:0] a, input logic [15:0] b, input int tol);
    logic [15:0] d1;
    logic [15:0] d2;
    d1 = a - b;
    d2 = b - a;
    return (int'(d1) <= tol) || (int'(d2) <= tol);
  endfunction

  // Ideal sine generator: phase -> offset-binary sample.
  function automatic logic [15:0] sg(input logic [15:0] p);
    real r;
    int  v;
    r = $sin(2.0 * 3.14159265358979 * real'(p) / 65536.0);
    v = int'(r * 32767.0);
    return 16'(v + 32768);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_near(input string nm, input logic [15:0] act, input logic [15:0] req,
                            input int tol);
    checks++;
    if (!near(act, req, tol)) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h +-%0d", nm, act, req, tol);
    end
  endtask

  // Monitor: every output handshake is scored against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %04h expected none", bus.o_saw);
      end else begin
        mon_e = sb_q.pop_front();
        if (!near(bus.o_saw, mon_e.saw, mon_e.tol)) begin
          errors++;
          $display("FAIL result_%0d: got %04h expected %04h +-%0d",
                   mon_e.id, bus.o_saw, mon_e.saw, mon_e.tol);
        end
      end
    end
  end

  task automatic send(input logic [15:0] c, input logic [15:0] s, input logic [15:0] exp_saw,
                      input int tol, input int id, input bit push);
    int   n;
    exp_t e;
    bus.i_cos   = c;
    bus.i_sin   = s;
    bus.i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_%0d: got o_ready=0 expected 1", id);
      bus.i_valid = 1'b0;
      return;
    end
    if (push) begin
      e.saw = exp_saw;
      e.tol = tol;
      e.id  = id;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !bus.o_ready) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (sb_q.size() != 0 || !bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout_%0d: got pending=%0d expected 0", id, sb_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] p;
    bus.i_cos   = 16'h8000;
    bus.i_sin   = 16'h8000;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_saw", 32'(bus.o_saw), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Quadrant vectors; first one also measures latency.
    send(16'hFFFF, 16'h8000, 16'h0000, 4, 1, 1'b1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'(ITER));
    send(16'h8000, 16'hFFFF, 16'h4000, 4, 2, 1'b1);
    send(16'h0000, 16'h8000, 16'h8000, 4, 3, 1'b1);
    send(16'h8000, 16'h0000, 16'hC000, 4, 4, 1'b1);
    send(16'hDA82, 16'hDA82, 16'h2000, 4, 5, 1'b1);
    send(16'hDA82, 16'h257E, 16'hE000, 4, 6, 1'b1);
    send(16'h8000, 16'h8000, 16'h0000, 0, 7, 1'b1);
    drain(1);

    // Loopback through an ideal sine generator.
    for (int i = 0; i < 256; i++) begin
      p = 16'(i * 257);
      send(sg(p + 16'h4000), sg(p), p, 4, 1000 + i, 1'b1);
    end
    drain(2);

    // Backpressure: result held while a new sample waits.
    bus.i_ready = 1'b0;
    send(16'h8000, 16'hFFFF, 16'h4000, 4, 20, 1'b1);
    bus.i_cos   = 16'h0000;
    bus.i_sin   = 16'h8000;
    bus.i_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) break;
    end
    check("bp_valid_seen", 32'(bus.o_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(bus.o_ready), 32'd0);
      check("bp_valid_held", 32'(bus.o_valid), 32'd1);
      check_near("bp_saw_held", bus.o_saw, 16'h4000, 4);
    end
    @(posedge clk);
    #1;
    mon_e.saw = 16'h8000;
    mon_e.tol = 4;
    mon_e.id  = 21;
    sb_q.push_back(mon_e);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after", 32'(bus.o_ready), 32'd1);
    check("bp_valid_after", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_held_taken", 32'(bus.o_ready), 32'd0);
    bus.i_valid = 1'b0;
    drain(3);

    // Reset in the middle of the rotation.
    send(16'hFFFF, 16'h8000, 16'h0000, 4, 30, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
    check("mid_rst_saw", 32'(bus.o_saw), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'hDA82, 16'hDA82, 16'h2000, 4, 31, 1'b1);
    drain(4);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
